// File: rtl/execute_pipe.sv
// Execute stage: ALU, condition codes and branch/cmov condition,
// feeding the registered memory-stage (M) pipeline fields.
module execute_pipe #(
  parameter int WIDTH = 64,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             M_stall,
  input  logic             M_bubble,
  input  logic             cc_suppress,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic             e_cnd,
  output logic [2:0]       cc
);

  localparam logic [3:0] I_NOP   = 4'd1;
  localparam logic [3:0] I_RRMOV = 4'd2;
  localparam logic [3:0] I_IRMOV = 4'd3;
  localparam logic [3:0] I_RMMOV = 4'd4;
  localparam logic [3:0] I_MRMOV = 4'd5;
  localparam logic [3:0] I_OP    = 4'd6;
  localparam logic [3:0] I_JXX   = 4'd7;
  localparam logic [3:0] I_CALL  = 4'd8;
  localparam logic [3:0] I_RET   = 4'd9;
  localparam logic [3:0] I_PUSH  = 4'd10;
  localparam logic [3:0] I_POP   = 4'd11;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [3:0] R_NONE = 4'hF;

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_r;
  logic [3:0]       alu_fn;
  logic             bad_op;
  logic             zf, sf, of;
  logic             set_cc;
  logic             cnd;

  logic [2:0]       stat_q;
  logic [3:0]       icode_q;
  logic             cnd_q;
  logic [WIDTH-1:0] valE_q;
  logic [WIDTH-1:0] valA_q;
  logic [3:0]       dstE_q;
  logic [3:0]       dstM_q;
  logic [2:0]       cc_q;
  logic [2:0]       cc_d;

  always_comb begin
    alu_a = '0;
    unique case (1'b1)
      (E_icode == I_RRMOV) || (E_icode == I_OP):
        alu_a = E_valA;
      (E_icode == I_IRMOV) || (E_icode == I_RMMOV) ||
      (E_icode == I_MRMOV):
        alu_a = E_valC;
      (E_icode == I_CALL) || (E_icode == I_PUSH):
        alu_a = '0 - STEP_V;
      (E_icode == I_RET) || (E_icode == I_POP):
        alu_a = STEP_V;
      default: alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    unique case (1'b1)
      (E_icode == I_RMMOV), (E_icode == I_MRMOV),
      (E_icode == I_OP),    (E_icode == I_CALL),
      (E_icode == I_RET),   (E_icode == I_PUSH),
      (E_icode == I_POP):
        alu_b = E_valB;
      default: alu_b = '0;
    endcase
  end

  assign alu_fn = (E_icode == I_OP) ? E_ifun : 4'd0;
  assign bad_op = (E_icode == I_OP) && (E_ifun > 4'd3);

  always_comb begin
    alu_r = '0;
    of    = 1'b0;
    case (alu_fn)
      4'd0: begin
        alu_r = alu_b + alu_a;
        of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
             (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
      end
      4'd1: begin
        alu_r = alu_b - alu_a;
        of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
             (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
      end
      4'd2: alu_r = alu_b & alu_a;
      4'd3: alu_r = alu_b ^ alu_a;
      default: begin
        alu_r = '0;
        of    = 1'b0;
      end
    endcase
  end

  assign zf = (alu_r == '0);
  assign sf = alu_r[WIDTH-1];

  assign set_cc = (E_icode == I_OP) && !bad_op &&
                  (E_stat == S_AOK) && !cc_suppress &&
                  !M_stall;

  // Condition comes only from the registered flags: no CC bypass
  always_comb begin
    cnd = 1'b0;
    case (E_ifun)
      4'd0: cnd = 1'b1;
      4'd1: cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'd2: cnd = cc_q[1] ^ cc_q[0];
      4'd3: cnd = cc_q[2];
      4'd4: cnd = ~cc_q[2];
      4'd5: cnd = ~(cc_q[1] ^ cc_q[0]);
      4'd6: cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default: cnd = 1'b0;
    endcase
  end

  assign e_cnd = ((E_icode == I_RRMOV) || (E_icode == I_JXX))
                 ? cnd : 1'b1;

  assign cc_d = set_cc ? {zf, sf, of} : cc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= 3'b100;
    end else begin
      cc_q <= cc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q  <= S_AOK;
      icode_q <= I_NOP;
      cnd_q   <= 1'b0;
      valE_q  <= '0;
      valA_q  <= '0;
      dstE_q  <= R_NONE;
      dstM_q  <= R_NONE;
    end else if (!M_stall) begin
      if (M_bubble) begin
        stat_q  <= S_AOK;
        icode_q <= I_NOP;
        cnd_q   <= 1'b0;
        valE_q  <= '0;
        valA_q  <= '0;
        dstE_q  <= R_NONE;
        dstM_q  <= R_NONE;
      end else begin
        stat_q  <= bad_op ? S_INS : E_stat;
        icode_q <= E_icode;
        cnd_q   <= e_cnd;
        valE_q  <= bad_op ? '0 : alu_r;
        valA_q  <= E_valA;
        dstE_q  <= ((E_icode == I_RRMOV) && !e_cnd)
                   ? R_NONE : E_dstE;
        dstM_q  <= E_dstM;
      end
    end
  end

  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_cnd   = cnd_q;
  assign M_valE  = valE_q;
  assign M_valA  = valA_q;
  assign M_dstE  = dstE_q;
  assign M_dstM  = dstM_q;
  assign cc      = cc_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: ALU, flags, conditions,
// stall/bubble priority and asynchronous reset.
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [3:0]  E_dstE, E_dstM;
  logic        M_stall, M_bubble, cc_suppress;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        e_cnd;
  logic [2:0]  cc;

  int total = 0;
  int bad   = 0;

  execute_pipe #(.WIDTH(64), .STEP(8)) dut (
    .clk(clk), .rst(rst),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .cc_suppress(cc_suppress),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM),
    .e_cnd(e_cnd), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic,
                       input logic [3:0] fn,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [3:0] de);
    E_stat  = 3'd1;
    E_icode = ic;
    E_ifun  = fn;
    E_valA  = a;
    E_valB  = b;
    E_valC  = 64'h0;
    E_dstE  = de;
    E_dstM  = 4'hF;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_stat"},  64'(M_stat),  64'd1);
    chk({tag, "_icode"}, 64'(M_icode), 64'd1);
    chk({tag, "_cnd"},   64'(M_cnd),   64'd0);
    chk({tag, "_valE"},  M_valE,       64'd0);
    chk({tag, "_valA"},  M_valA,       64'd0);
    chk({tag, "_dstE"},  64'(M_dstE),  64'hF);
    chk({tag, "_dstM"},  64'(M_dstM),  64'hF);
  endtask

  initial begin
    rst = 1'b1;
    M_stall = 1'b0;
    M_bubble = 1'b0;
    cc_suppress = 1'b0;
    drive(4'd1, 4'd0, 64'h0, 64'h0, 4'hF);
    #2;
    chk_nop("reset");
    chk("reset_cc", 64'(cc), 64'b100);
    rst = 1'b0;

    drive(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'd2);
    E_dstM = 4'd9;
    tick();
    chk("add_valE", M_valE, 64'h8000_0000_0000_0000);
    chk("add_cc", 64'(cc), 64'b011);
    chk("add_icode", 64'(M_icode), 64'd6);
    chk("add_dstE", 64'(M_dstE), 64'd2);
    chk("add_dstM", 64'(M_dstM), 64'd9);
    chk("add_valA", M_valA, 64'h7FFF_FFFF_FFFF_FFFF);

    drive(4'd6, 4'd1, 64'd5, 64'd5, 4'd2);
    #1;
    chk("sub_cc_before_edge", 64'(cc), 64'b011);
    tick();
    chk("sub_valE", M_valE, 64'd0);
    chk("sub_cc", 64'(cc), 64'b100);

    drive(4'd7, 4'd3, 64'h0, 64'h0, 4'hF);
    #1;
    chk("je_cnd", 64'(e_cnd), 64'd1);
    E_ifun = 4'd4;
    #1;
    chk("jne_cnd", 64'(e_cnd), 64'd0);
    tick();
    chk("jne_Mcnd", 64'(M_cnd), 64'd0);

    drive(4'd6, 4'd1, 64'd1, 64'd0, 4'd4);
    tick();
    chk("sub_neg_cc", 64'(cc), 64'b010);
    drive(4'd2, 4'd2, 64'h55, 64'h0, 4'd3);
    tick();
    chk("cmovl_t_dstE", 64'(M_dstE), 64'd3);
    chk("cmovl_t_valE", M_valE, 64'h55);
    chk("cmovl_t_cnd", 64'(M_cnd), 64'd1);

    drive(4'd6, 4'd1, 64'd5, 64'd5, 4'd2);
    tick();
    drive(4'd2, 4'd2, 64'h55, 64'h0, 4'd3);
    tick();
    chk("cmovl_f_dstE", 64'(M_dstE), 64'hF);

    drive(4'd10, 4'd0, 64'h0, 64'h100, 4'd4);
    tick();
    chk("push_valE", M_valE, 64'hF8);
    drive(4'd11, 4'd0, 64'h0, 64'h100, 4'd4);
    tick();
    chk("pop_valE", M_valE, 64'h108);
    chk("pushpop_cc", 64'(cc), 64'b100);

    drive(4'd6, 4'd0, 64'd1, 64'd1, 4'd5);
    cc_suppress = 1'b1;
    tick();
    chk("supp_valE", M_valE, 64'd2);
    chk("supp_cc", 64'(cc), 64'b100);
    cc_suppress = 1'b0;

    drive(4'd6, 4'd1, 64'd1, 64'd0, 4'd6);
    M_stall = 1'b1;
    tick();
    chk("stall_valE", M_valE, 64'd2);
    chk("stall_dstE", 64'(M_dstE), 64'd5);
    chk("stall_cc", 64'(cc), 64'b100);
    M_bubble = 1'b1;
    tick();
    chk("stallbub_valE", M_valE, 64'd2);
    chk("stallbub_icode", 64'(M_icode), 64'd6);
    M_stall = 1'b0;
    tick();
    chk_nop("bubble");
    chk("bubble_cc", 64'(cc), 64'b010);
    M_bubble = 1'b0;

    drive(4'd6, 4'd5, 64'd3, 64'd4, 4'd2);
    tick();
    chk("badop_stat", 64'(M_stat), 64'd4);
    chk("badop_valE", M_valE, 64'd0);
    chk("badop_cc", 64'(cc), 64'b010);

    drive(4'd6, 4'd0, 64'd1, 64'd1, 4'd7);
    tick();
    chk("pre_rst_valE", M_valE, 64'd2);
    chk("pre_rst_cc", 64'(cc), 64'b000);
    M_stall = 1'b1;
    M_bubble = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_nop("midrst");
    chk("midrst_cc", 64'(cc), 64'b100);
    tick();
    M_stall = 1'b0;
    M_bubble = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_rel_cc", 64'(cc), 64'b100);
    tick();
    chk("post_rst_valE", M_valE, 64'd2);
    chk("post_rst_cc", 64'(cc), 64'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
